// File: rtl/usb_tx_nrzi_pkg.sv
// rtl/usb_tx_nrzi_pkg.sv - shared states, line encodings and NRZI helper for usb_tx_nrzi
package usb_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_STUFF,
        ST_ABORT,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    // {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // Sent LSB-first: seven zeros then a one
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    function automatic logic [1:0] nrzi_next(input logic [1:0] cur, input logic bit_i);
        if (bit_i) begin
            return cur;
        end
        return (cur == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb_tx_nrzi_if.sv
// rtl/usb_tx_nrzi_if.sv - bit-serial payload handshake between packet serialiser and line driver
interface usb_tx_nrzi_if;

    logic tx_data;
    logic tx_valid;
    logic tx_last;
    logic tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/usb_tx_nrzi_bit_timer.sv
// rtl/usb_tx_nrzi_bit_timer.sv - free-running bit period counter with clear and end-of-bit strobe
module usb_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr_i,
    output logic bit_end_o
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_end_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/usb_tx_nrzi.sv
// rtl/usb_tx_nrzi.sv - USB LS/FS transmit line driver: SYNC, bit stuffing, NRZI, underrun abort, EOP
module usb_tx_nrzi
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LEN    = 6,
    parameter int EOP_SE0_BITS = 2
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          tx_start,
    usb_tx_nrzi_if.slave  tx_if,
    output logic          tx_busy,
    output logic          tx_err,
    output logic          d_plus,
    output logic          d_minus
);

    localparam int ONES_W   = $clog2(STUFF_LEN + 1);
    localparam int SLOT_A   = (STUFF_LEN > 7) ? STUFF_LEN : 7;
    localparam int SLOT_MAX = ((EOP_SE0_BITS - 1) > SLOT_A) ? (EOP_SE0_BITS - 1) : SLOT_A;
    localparam int SLOT_W   = $clog2(SLOT_MAX + 1);

    localparam logic [ONES_W-1:0] ONES_MAX   = ONES_W'(STUFF_LEN);
    localparam logic [SLOT_W-1:0] SYNC_LAST  = SLOT_W'(7);
    localparam logic [SLOT_W-1:0] ABORT_LAST = SLOT_W'(STUFF_LEN);
    localparam logic [SLOT_W-1:0] SE0_LAST   = SLOT_W'(EOP_SE0_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        line_q, line_d;
    logic              last_q, last_d;
    logic              pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic              err_q, err_d;

    logic       bit_end;
    logic       take_bit;
    logic [2:0] sync_nxt;
    logic       sync_bit;

    usb_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .clr_i     (state_q == ST_IDLE),
        .bit_end_o (bit_end)
    );

    assign sync_nxt = slot_q[2:0] + 3'd1;
    assign sync_bit = SYNC_PATTERN[sync_nxt];

    // A payload bit is requested only where the slot after this one carries payload
    assign take_bit = bit_end &&
                      (((state_q == ST_SYNC) && (slot_q == SYNC_LAST)) ||
                       ((state_q == ST_DATA) && !last_q));

    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        slot_d     = slot_q;
        line_d     = line_q;
        last_d     = last_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                line_d = LINE_J;
                if (tx_start) begin
                    state_d    = ST_SYNC;
                    slot_d     = '0;
                    line_d     = nrzi_next(LINE_J, SYNC_PATTERN[0]);
                    ones_d     = SYNC_PATTERN[0] ? ONES_W'(1) : '0;
                    last_d     = 1'b0;
                    pend_vld_d = 1'b0;
                end
            end
            ST_SYNC: begin
                if (bit_end && (slot_q != SYNC_LAST)) begin
                    slot_d = slot_q + 1'b1;
                    line_d = nrzi_next(line_q, sync_bit);
                    ones_d = sync_bit ? (ones_q + 1'b1) : '0;
                end
            end
            ST_DATA: begin
                // A final bit that completes a run still gets its stuff bit
                if (bit_end && last_q) begin
                    if (ones_q == ONES_MAX) begin
                        state_d    = ST_STUFF;
                        line_d     = nrzi_next(line_q, 1'b0);
                        ones_d     = '0;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = ST_EOP_SE0;
                        line_d  = LINE_SE0;
                        slot_d  = '0;
                    end
                end
            end
            ST_STUFF: begin
                if (bit_end) begin
                    if (pend_vld_q) begin
                        state_d    = ST_DATA;
                        line_d     = nrzi_next(line_q, pend_q);
                        ones_d     = pend_q ? ONES_W'(1) : '0;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = ST_EOP_SE0;
                        line_d  = LINE_SE0;
                        slot_d  = '0;
                    end
                end
            end
            ST_ABORT: begin
                if (bit_end) begin
                    if (slot_q == ABORT_LAST) begin
                        state_d = ST_EOP_SE0;
                        line_d  = LINE_SE0;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_end) begin
                    if (slot_q == SE0_LAST) begin
                        state_d = ST_EOP_J;
                        line_d  = LINE_J;
                        slot_d  = '0;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    line_d  = LINE_J;
                    ones_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                line_d  = LINE_J;
            end
        endcase

        // When a stuff bit is due, the requested bit is parked until the stuff slot ends
        if (take_bit) begin
            if (!tx_if.tx_valid) begin
                state_d = ST_ABORT;
                slot_d  = '0;
                err_d   = 1'b1;
            end else if (ones_q == ONES_MAX) begin
                state_d    = ST_STUFF;
                line_d     = nrzi_next(line_q, 1'b0);
                ones_d     = '0;
                pend_d     = tx_if.tx_data;
                pend_vld_d = 1'b1;
                last_d     = tx_if.tx_last;
            end else begin
                state_d = ST_DATA;
                line_d  = nrzi_next(line_q, tx_if.tx_data);
                ones_d  = tx_if.tx_data ? (ones_q + 1'b1) : '0;
                last_d  = tx_if.tx_last;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            ones_q     <= '0;
            slot_q     <= '0;
            line_q     <= LINE_J;
            last_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ones_q     <= ones_d;
            slot_q     <= slot_d;
            line_q     <= line_d;
            last_q     <= last_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            err_q      <= err_d;
        end
    end

    assign tx_if.tx_ready = take_bit;
    assign tx_busy        = (state_q != ST_IDLE);
    assign tx_err         = err_q;
    assign d_plus         = line_q[1];
    assign d_minus        = line_q[0];

endmodule

// File: tb/tb_usb_tx_nrzi.sv
// tb/tb_usb_tx_nrzi.sv - directed self-checking bench for usb_tx_nrzi at 4 and 8 clocks per bit
module tb_usb_tx_nrzi;

    logic clk = 1'b0;
    logic n_rst;
    logic start4, start8;
    logic busy4, err4, dp4, dm4;
    logic busy8, err8, dp8, dm8;

    int errors = 0;
    int checks = 0;

    logic [1:0] cap[$];
    logic       rdy_h[$];
    int n_busy, n_rdy, n_cons, n_err;

    always #5 clk = ~clk;

    usb_tx_nrzi_if if4 ();
    usb_tx_nrzi_if if8 ();

    usb_tx_nrzi #(.CLKS_PER_BIT(4), .STUFF_LEN(6), .EOP_SE0_BITS(2)) dut4 (
        .clk(clk), .n_rst(n_rst), .tx_start(start4), .tx_if(if4),
        .tx_busy(busy4), .tx_err(err4), .d_plus(dp4), .d_minus(dm4)
    );

    usb_tx_nrzi #(.CLKS_PER_BIT(8), .STUFF_LEN(6), .EOP_SE0_BITS(2)) dut8 (
        .clk(clk), .n_rst(n_rst), .tx_start(start8), .tx_if(if8),
        .tx_busy(busy8), .tx_err(err8), .d_plus(dp8), .d_minus(dm8)
    );

    task automatic drive(input int sel, input logic s, input logic d, input logic v, input logic l);
        if (sel == 8) begin
            start8 = s; if8.tx_data = d; if8.tx_valid = v; if8.tx_last = l;
        end else begin
            start4 = s; if4.tx_data = d; if4.tx_valid = v; if4.tx_last = l;
        end
    endtask

    task automatic sample(input int sel, output logic [1:0] ln, output logic b, output logic r, output logic e);
        if (sel == 8) begin
            ln = {dp8, dm8}; b = busy8; r = if8.tx_ready; e = err8;
        end else begin
            ln = {dp4, dm4}; b = busy4; r = if4.tx_ready; e = err4;
        end
    endtask

    function automatic logic [1:0] ch2line(input byte c);
        if (c == "J") return 2'b10;
        if (c == "K") return 2'b01;
        return 2'b00;
    endfunction

    // Index of first captured cycle that disagrees with the slot string, -1 if all agree
    function automatic int seq_mismatch(input string exp, input int cpb);
        if (cap.size() != exp.len() * cpb) return cap.size();
        for (int i = 0; i < cap.size(); i++) begin
            if (cap[i] !== ch2line(exp[i / cpb])) return i;
        end
        return -1;
    endfunction

    // Starts a packet, feeds payload on ready, records one entry per busy cycle
    task automatic run_pkt(input int sel, input logic [7:0] payload, input int nbits,
                           input bit give, input int restart_at, input bit start_now);
        int idx = 0;
        bit done = 0;
        logic [1:0] ln;
        logic b, r, e, v;
        cap.delete(); rdy_h.delete();
        n_busy = 0; n_rdy = 0; n_cons = 0; n_err = 0;
        if (!start_now) @(negedge clk);
        drive(sel, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int cyc = 1; cyc < 600 && !done; cyc++) begin
            v = give && (idx < nbits);
            drive(sel, cyc == restart_at, v ? payload[idx] : 1'b0, v, v && (idx == nbits - 1));
            #1;
            sample(sel, ln, b, r, e);
            if (b) begin
                cap.push_back(ln);
                rdy_h.push_back(r);
                n_busy++;
                if (r) n_rdy++;
                if (r && v) begin n_cons++; idx++; end
                if (e) n_err++;
                @(negedge clk);
            end else begin
                done = 1;
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL run_pkt_timeout: busy never fell, got %0d busy cycles", n_busy);
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        drive(4, 0, 0, 0, 0);
        drive(8, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if ({dp4, dm4} !== 2'b10) begin errors++; $display("FAIL reset_line4: got %b want 10", {dp4, dm4}); end
        checks++;
        if ({busy4, if4.tx_ready, err4} !== 3'b000) begin errors++; $display("FAIL reset_ctl4: got %b want 000", {busy4, if4.tx_ready, err4}); end
        checks++;
        if ({dp8, dm8} !== 2'b10) begin errors++; $display("FAIL reset_line8: got %b want 10", {dp8, dm8}); end
        checks++;
        if ({busy8, if8.tx_ready, err8} !== 3'b000) begin errors++; $display("FAIL reset_ctl8: got %b want 000", {busy8, if8.tx_ready, err8}); end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_payload;
        int mis, bad;
        run_pkt(4, 8'h00, 8, 1, 0, 0);
        mis = seq_mismatch("KJKJKJKKJKJKJKJK00J", 4);
        checks++;
        if (mis !== -1) begin errors++; $display("FAIL zero_lines: mismatch at cycle index %0d want -1", mis); end
        checks++;
        if (n_busy !== 76) begin errors++; $display("FAIL zero_busy: got %0d want 76", n_busy); end
        checks++;
        if (n_rdy !== 8) begin errors++; $display("FAIL zero_ready: got %0d want 8", n_rdy); end
        checks++;
        if (n_cons !== 8) begin errors++; $display("FAIL zero_consumed: got %0d want 8", n_cons); end
        checks++;
        if (n_err !== 0) begin errors++; $display("FAIL zero_err: got %0d want 0", n_err); end
        bad = 0;
        for (int i = 0; i < rdy_h.size(); i++) if (rdy_h[i] && (i % 4) != 3) bad++;
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL zero_ready_phase: got %0d off-phase pulses want 0", bad); end
    endtask

    task automatic test_stuffing;
        int mis, stuff_rdy;
        run_pkt(4, 8'hFF, 8, 1, 0, 0);
        mis = seq_mismatch("KJKJKJKKKKKKKJJJJ00J", 4);
        checks++;
        if (mis !== -1) begin errors++; $display("FAIL stuff_lines: mismatch at cycle index %0d want -1", mis); end
        checks++;
        if (n_busy !== 80) begin errors++; $display("FAIL stuff_busy: got %0d want 80", n_busy); end
        checks++;
        if (n_cons !== 8) begin errors++; $display("FAIL stuff_consumed: got %0d want 8", n_cons); end
        checks++;
        if (n_rdy !== 8) begin errors++; $display("FAIL stuff_ready: got %0d want 8", n_rdy); end
        stuff_rdy = 0;
        for (int i = 52; i < 56 && i < rdy_h.size(); i++) if (rdy_h[i]) stuff_rdy++;
        checks++;
        if (stuff_rdy !== 0) begin errors++; $display("FAIL stuff_slot_ready: got %0d want 0", stuff_rdy); end
    endtask

    task automatic test_underrun;
        int mis;
        run_pkt(4, 8'h00, 8, 0, 0, 0);
        mis = seq_mismatch("KJKJKJKKKKKKKKK00J", 4);
        checks++;
        if (mis !== -1) begin errors++; $display("FAIL underrun_lines: mismatch at cycle index %0d want -1", mis); end
        checks++;
        if (n_err !== 1) begin errors++; $display("FAIL underrun_err: got %0d want 1", n_err); end
        checks++;
        if (n_cons !== 0) begin errors++; $display("FAIL underrun_consumed: got %0d want 0", n_cons); end
        checks++;
        if (n_busy !== 72) begin errors++; $display("FAIL underrun_busy: got %0d want 72", n_busy); end
    endtask

    task automatic test_slow_bits;
        int mis, busy_after;
        run_pkt(8, 8'h01, 8, 1, 50, 0);
        mis = seq_mismatch("KJKJKJKKKJKJKJKJ00J", 8);
        checks++;
        if (mis !== -1) begin errors++; $display("FAIL slow_lines: mismatch at cycle index %0d want -1", mis); end
        checks++;
        if (n_busy !== 152) begin errors++; $display("FAIL slow_busy: got %0d want 152", n_busy); end
        checks++;
        if (n_cons !== 8) begin errors++; $display("FAIL slow_consumed: got %0d want 8", n_cons); end
        busy_after = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy8 || {dp8, dm8} != 2'b10) busy_after++;
        end
        checks++;
        if (busy_after !== 0) begin errors++; $display("FAIL slow_no_restart: got %0d active cycles want 0", busy_after); end
    endtask

    task automatic test_back_to_back;
        int mis;
        @(negedge clk);
        drive(4, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(4, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (39) @(negedge clk);
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy4); end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({dp4, dm4, busy4, if4.tx_ready, err4} !== 5'b10000) begin
            errors++; $display("FAIL mid_reset_outputs: got %b want 10000", {dp4, dm4, busy4, if4.tx_ready, err4});
        end
        drive(4, 0, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        run_pkt(4, 8'h00, 8, 1, 0, 0);
        mis = seq_mismatch("KJKJKJKKJKJKJKJK00J", 4);
        checks++;
        if (mis !== -1) begin errors++; $display("FAIL post_reset_lines: mismatch at cycle index %0d want -1", mis); end
        run_pkt(4, 8'h00, 8, 1, 0, 1);
        mis = seq_mismatch("KJKJKJKKJKJKJKJK00J", 4);
        checks++;
        if (mis !== -1) begin errors++; $display("FAIL b2b_lines: mismatch at cycle index %0d want -1", mis); end
        checks++;
        if (n_busy !== 76) begin errors++; $display("FAIL b2b_busy: got %0d want 76", n_busy); end
    endtask

    initial begin
        start4 = 1'b0;
        start8 = 1'b0;
        n_rst  = 1'b0;
        test_reset();
        test_zero_payload();
        test_stuffing();
        test_underrun();
        test_slow_bits();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_tx_nrzi.md
# usb_tx_nrzi

Parametrised USB low/full-speed serial transmitter line driver that replaces the fixed one-bit-per-clock NRZI encoder. It takes a bit-serial payload over a valid/ready handshake and prepends SYNC automatically. It performs bit stuffing, NRZI encoding with a configurable bit period, underrun abort and EOP generation, and drives d_plus/d_minus directly. It sits between the packet serialiser (PID/data/CRC shifters) and the pad drivers.

## Interface
- CLKS_PER_BIT, 8: clk cycles per USB bit period; legal values ≥ 2.
- STUFF_LEN, 6: consecutive logical ones that force a stuffed zero.
- EOP_SE0_BITS, 2: SE0 bit periods in EOP; EOP_SE0_BITS ≥ 1.
- clk  in  1  system clock.
- n_rst  in  1  reset. One clock; reset is asynchronous and active-low.
- tx_start  in  1  single-cycle request to begin a packet; ignored unless idle.
- tx_data  in  1  next logical payload bit, LSB-first order supplied by the upstream block.
- tx_valid  in  1  tx_data is valid.
- tx_last  in  1  qualifies tx_data as the final payload bit.
- tx_ready  out  1  payload bit is consumed this cycle when tx_valid & tx_ready.
- tx_busy  out  1  packet in progress, from SYNC through the EOP J bit.
- tx_err  out  1  one-cycle pulse on underrun abort.
- d_plus  out  1  USB D+ line, registered.
- d_minus  out  1  USB D− line, registered.

## Operation
- Line states: J = (1,0), K = (0,1), SE0 = (0,0).
- Reset values: d_plus=1, d_minus=0, tx_busy=0, tx_ready=0, tx_err=0. The FSM resets to IDLE, the bit timer to 0 and the ones counter to 0.
- FSM states: IDLE, SYNC, DATA, STUFF, ABORT, EOP_SE0, EOP_J.
- IDLE: drives J. tx_start moves the FSM to SYNC.
- SYNC: sends logical 00000001 over 8 bit periods, giving KJKJKJKK on the line. The ones counter leaves SYNC at 1.
- NRZI rule: a logical 0 toggles J↔K; a logical 1 holds the current level.
- DATA slot: if tx_valid is low when the bit is sampled, the FSM goes to ABORT.
- Ones counter: a 1 increments it and a 0 clears it.
  - When it reaches STUFF_LEN, the next slot is STUFF.
  - Otherwise, if the sampled bit had tx_last set, the FSM goes to EOP_SE0; if not, the next slot is DATA.
- STUFF: drives a logical 0 (toggle) and clears the counter. tx_ready stays low for this whole slot. After the slot, the FSM goes to EOP_SE0 if the pending tx_last flag is set, otherwise to DATA. A stuff bit is therefore sent after a final bit that completes a run.
- ABORT: holds the current level, with no toggles, for STUFF_LEN+1 bit periods, then goes to EOP_SE0. tx_err pulses in the first ABORT cycle. tx_ready is low throughout.
- EOP_SE0: SE0 for EOP_SE0_BITS bit periods, then EOP_J.
- EOP_J: J for 1 bit period, then IDLE. The ones counter clears.
- Widths: bit timer is $clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT−1. Ones counter is $clog2(STUFF_LEN+1) bits and never exceeds STUFF_LEN.

## Timing
- tx_start sampled in cycle 0 → first SYNC K visible on d_plus/d_minus in cycle 1.
- Every line level is held exactly CLKS_PER_BIT cycles.
- tx_ready is high only in the last cycle (timer = CLKS_PER_BIT−1) of a SYNC or DATA bit period whose following slot is DATA.
- The bit sampled in that cycle appears on the lines in the next cycle.
- tx_busy rises in cycle 1 and falls in the cycle after the last EOP_J cycle, when the lines are already J.
- tx_start while busy is ignored. tx_start in the same cycle tx_busy falls is honoured.
- tx_valid or tx_last outside a tx_ready cycle has no effect.
- n_rst low mid-packet: outputs take their reset values immediately (J, not busy). No EOP is sent.

## Structure
- Package usb_tx_pkg holds:
  - the state enum;
  - the line-state constants J, K and SE0;
  - the SYNC_PATTERN constant, 8'h80, shifted LSB-first.
- One sub-module, usb_bit_timer: a parametrised CLKS_PER_BIT counter with clear and a bit_end strobe.
- FSM, stuffing, NRZI and output registers live in usb_tx_nrzi.

## Test plan
All scenarios use CLKS_PER_BIT=4 unless stated.
- Reset: hold n_rst low → d_plus=1, d_minus=0, tx_busy=0, tx_ready=0, tx_err=0.
- Payload 0x00 (8 bits, tx_last on the 8th):
  - lines KJKJKJKK JKJKJKJK, then SE0 ×2 bits, then J ×1 bit;
  - tx_busy high for 76 cycles;
  - 8 tx_ready pulses.
- Payload 0xFF:
  - after SYNC: K ×5, stuffed J, J ×3, then EOP;
  - tx_ready low during the stuff slot;
  - 9 payload-slot periods total.
- Underrun: tx_valid=0 at the first tx_ready:
  - tx_err pulses once;
  - lines hold K for 7 bit periods, then SE0 ×2 and J ×1;
  - no data is consumed.
- CLKS_PER_BIT=8, payload 0x01: every level is held exactly 8 cycles; a second tx_start mid-packet is ignored (no re-SYNC).
- Reset asserted during the DATA state → same-cycle J/idle outputs; after release, a fresh tx_start produces a correct full packet.
